// File: rtl/rv32i_exec_slice.sv
// -----------------------------------------------------------------------------
// rv32i_exec_slice
//
// Single-cycle RV32I execution slice: 32x32 register file, instruction decoder,
// ALU and load/store access control with register write-back.
// Decode, ALU, memory address/enables and the load data extension are all
// combinational. The only state is the register file, which is written on the
// rising clock edge.
//
// Memory port contract: read_enable / write_enable qualify address,
// write_data and write_wstrb for the current cycle only. There is no ready or
// stall; the memory must return read_data within the same cycle. The fetch
// side presents a new instruction every cycle.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-high; clears the register file
//   instruction   in   current instruction word
//   pc            in   address of the current instruction (reserved, unused)
//   address       out  data memory address (always equals alu_out)
//   read_data     in   load data, right-aligned to bit 0
//   read_enable   out  high for a valid load
//   write_data    out  store data (rs2 value, unmasked)
//   write_enable  out  high for a valid store
//   write_wstrb   out  access width: 0=byte, 1=half, 2=word
//   alu_out       out  ALU result
//   debug_ebreak  out  high when the instruction is EBREAK
//   debug_reg     out  (DEBUG_REG_EN only) flat copy of x0..x31, x0 field 0
//
// Optional feature: define DEBUG_REG_EN to add the debug_reg output port.
// -----------------------------------------------------------------------------
module rv32i_exec_slice #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  output logic [31:0] address,
  input  logic [31:0] read_data,
  output logic        read_enable,
  output logic [31:0] write_data,
  output logic        write_enable,
  output logic [1:0]  write_wstrb,
  output logic [31:0] alu_out,
  output logic        debug_ebreak
`ifdef DEBUG_REG_EN
  ,
  output logic [1023:0] debug_reg
`endif
);

  // Shift amount width follows the datapath width (5 bits for 32).
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [1:0] WSTRB_BYTE = 2'd0;
  localparam logic [1:0] WSTRB_HALF = 2'd1;
  localparam logic [1:0] WSTRB_WORD = 2'd2;

  localparam logic [31:0] EBREAK_WORD = 32'h00100073;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        alt_bit;
  logic [31:0] imm_i;
  logic [31:0] imm_s;

  assign opcode  = instruction[6:0];
  assign rd      = instruction[11:7];
  assign funct3  = instruction[14:12];
  assign rs1     = instruction[19:15];
  assign rs2     = instruction[24:20];
  // instr[30] selects SUB/SRA (R-type) and SRAI (I-type).
  assign alt_bit = instruction[30];
  assign imm_i   = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};

  // pc is reserved for future PC-relative instructions.
  logic unused_pc;
  assign unused_pc = ^pc;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] regs [32];
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        wb_en;
  logic [31:0] wb_data;

  // x0 is hardwired to zero on the read side; its storage is never written.
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  // Asynchronous reset wins over any write-back pending in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (wb_en) begin
      regs[rd] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [31:0] op2;
  logic [2:0]  alu_f3;
  logic        alu_alt;
  logic        is_load;
  logic        is_store;
  logic        wb_alu;
  logic [1:0]  wstrb;

  // Anything not recognised falls back to rs1 + I-imm with no side effects.
  always_comb begin
    op2      = imm_i;
    alu_f3   = F3_ADD;
    alu_alt  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    wb_alu   = 1'b0;
    wstrb    = WSTRB_WORD;
    case (opcode)
      OPC_R: begin
        op2     = rs2_val;
        alu_f3  = funct3;
        alu_alt = alt_bit;
        wb_alu  = 1'b1;
      end
      OPC_I: begin
        alu_f3  = funct3;
        // There is no SUBI: only the right shift honours instr[30].
        alu_alt = (funct3 == F3_SR) ? alt_bit : 1'b0;
        wb_alu  = 1'b1;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b100: begin
            is_load = 1'b1;
            wstrb   = WSTRB_BYTE;
          end
          3'b001, 3'b101: begin
            is_load = 1'b1;
            wstrb   = WSTRB_HALF;
          end
          3'b010: begin
            is_load = 1'b1;
            wstrb   = WSTRB_WORD;
          end
          default: begin
            is_load = 1'b0;
          end
        endcase
      end
      OPC_STORE: begin
        op2 = imm_s;
        case (funct3)
          3'b000: begin
            is_store = 1'b1;
            wstrb    = WSTRB_BYTE;
          end
          3'b001: begin
            is_store = 1'b1;
            wstrb    = WSTRB_HALF;
          end
          3'b010: begin
            is_store = 1'b1;
            wstrb    = WSTRB_WORD;
          end
          default: begin
            is_store = 1'b0;
          end
        endcase
      end
      default: begin
        op2 = imm_i;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [31:0]        alu_result;

  assign shamt = op2[SHAMT_W-1:0];

  always_comb begin
    alu_result = 32'h0;
    case (alu_f3)
      F3_ADD:  alu_result = alu_alt ? (rs1_val - op2) : (rs1_val + op2);
      F3_SLL:  alu_result = rs1_val << shamt;
      F3_SLT:  alu_result = {31'h0, ($signed(rs1_val) < $signed(op2))};
      F3_SLTU: alu_result = {31'h0, (rs1_val < op2)};
      F3_XOR:  alu_result = rs1_val ^ op2;
      F3_SR:   alu_result = alu_alt ? 32'($signed(rs1_val) >>> shamt)
                                    : (rs1_val >> shamt);
      F3_OR:   alu_result = rs1_val | op2;
      F3_AND:  alu_result = rs1_val & op2;
      default: alu_result = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extension (funct3[2] distinguishes the unsigned variants)
  // ---------------------------------------------------------------------------
  logic [31:0] load_value;

  always_comb begin
    load_value = read_data;
    case (funct3)
      3'b000:  load_value = {{24{read_data[7]}},  read_data[7:0]};
      3'b001:  load_value = {{16{read_data[15]}}, read_data[15:0]};
      3'b100:  load_value = {24'h0, read_data[7:0]};
      3'b101:  load_value = {16'h0, read_data[15:0]};
      default: load_value = read_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-back select and outputs
  // ---------------------------------------------------------------------------
  assign wb_en   = (wb_alu || is_load) && (rd != 5'd0) && !reset;
  assign wb_data = is_load ? load_value : alu_result;

  assign alu_out      = alu_result;
  assign address      = alu_result;
  assign write_data   = rs2_val;
  assign write_wstrb  = wstrb;
  assign read_enable  = is_load && !reset;
  assign write_enable = is_store && !reset;
  assign debug_ebreak = (instruction == EBREAK_WORD);

`ifdef DEBUG_REG_EN
  assign debug_reg[31:0] = 32'h0;
  for (genvar g = 1; g < 32; g++) begin : g_debug_reg
    assign debug_reg[32*g +: 32] = regs[g];
  end
`endif

endmodule

// File: tb/tb_rv32i_exec_slice.sv
// -----------------------------------------------------------------------------
// tb_rv32i_exec_slice
//
// Drives instructions one per cycle just after the rising edge. For every
// instruction the reference model predicts the combinational outputs and the
// register update; the prediction goes into exp_q. A monitor on the falling
// edge pops one entry per presented instruction and compares. Register
// contents are observed by issuing ADD x0,xN,x0 and checking alu_out.
// -----------------------------------------------------------------------------
module tb_rv32i_exec_slice;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] address;
  logic [31:0] read_data;
  logic        read_enable;
  logic [31:0] write_data;
  logic        write_enable;
  logic [1:0]  write_wstrb;
  logic [31:0] alu_out;
  logic        debug_ebreak;
`ifdef DEBUG_REG_EN
  logic [1023:0] debug_reg;
`endif

  rv32i_exec_slice dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .pc           (pc),
    .address      (address),
    .read_data    (read_data),
    .read_enable  (read_enable),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_wstrb  (write_wstrb),
    .alu_out      (alu_out),
    .debug_ebreak (debug_ebreak)
`ifdef DEBUG_REG_EN
    ,
    .debug_reg    (debug_reg)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] alu;
    logic        re;
    logic        we;
    logic [1:0]  wstrb;
    logic        chk_wstrb;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        ebreak;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] wb_val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mregs [32];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction encoders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = b % 32;
    r = 32'h0;
    case (op)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << s;
      3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> s;
        if (alt && a[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rdata);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] bv;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] v;
    opc   = ins[6:0];
    f3    = ins[14:12];
    a     = mregs[ins[19:15]];
    bv    = mregs[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    e = '0;
    e.wstrb     = 2'd2;
    e.chk_wstrb = 1'b1;
    e.wdata     = bv;
    e.ebreak    = (ins == 32'h00100073);
    e.rd        = ins[11:7];
    if (opc == 7'h33) begin
      e.alu    = alu_ref(f3, ins[30], a, bv);
      e.wb     = 1'b1;
      e.wb_val = e.alu;
    end else if (opc == 7'h13) begin
      e.alu    = alu_ref(f3, (f3 == 3'd5) ? ins[30] : 1'b0, a, imm_i);
      e.wb     = 1'b1;
      e.wb_val = e.alu;
    end else if (opc == 7'h03) begin
      e.alu = a + imm_i;
      v = rdata;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = rdata & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        e.wstrb = 2'd0;
        e.re = 1'b1;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        v = rdata & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        e.wstrb = 2'd1;
        e.re = 1'b1;
      end else if (f3 == 3'd2) begin
        e.wstrb = 2'd2;
        e.re = 1'b1;
      end else begin
        e.chk_wstrb = 1'b0;
      end
      e.wb     = e.re;
      e.wb_val = v;
    end else if (opc == 7'h23) begin
      e.alu = a + imm_s;
      if (f3 == 3'd0)      begin e.we = 1'b1; e.wstrb = 2'd0; end
      else if (f3 == 3'd1) begin e.we = 1'b1; e.wstrb = 2'd1; end
      else if (f3 == 3'd2) begin e.we = 1'b1; e.wstrb = 2'd2; end
      else e.chk_wstrb = 1'b0;
      e.chk_wdata = e.we;
    end else begin
      e.alu = a + imm_i;
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // use_k forces the expected alu_out to a hand-derived constant.
  task automatic issue_k(input logic [31:0] ins, input logic [31:0] rdata,
                         input bit use_k, input logic [31:0] alu_k);
    exp_t e;
    @(posedge clock);
    #1;
    instruction = ins;
    read_data   = rdata;
    pc          = pc + 32'd4;
    e = model(ins, rdata);
    if (use_k) e.alu = alu_k;
    exp_q.push_back(e);
    if (e.wb && e.rd != 5'd0) mregs[e.rd] = e.wb_val;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rdata);
    issue_k(ins, rdata, 1'b0, 32'h0);
  endtask

  // ADD x0,xN,x0 exposes xN on alu_out without changing state.
  task automatic read_reg(input logic [4:0] n, input logic [31:0] val);
    issue_k(enc_r(7'h00, 5'd0, n, 3'd0, 5'd0), 32'h0, 1'b1, val);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        check("alu_out",      alu_out,               m.alu);
        check("address",      address,               m.alu);
        check("read_enable",  32'(read_enable),      32'(m.re));
        check("write_enable", 32'(write_enable),     32'(m.we));
        check("debug_ebreak", 32'(debug_ebreak),     32'(m.ebreak));
        if (m.chk_wstrb) check("write_wstrb", 32'(write_wstrb), 32'(m.wstrb));
        if (m.chk_wdata) check("write_data",  write_data,       m.wdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    model_reset();
    pc          = 32'h0;
    read_data   = 32'h0;
    reset       = 1'b1;
    instruction = enc_s(12'h0, 5'd1, 5'd0, 3'd2);   // SW while in reset
    #2;
    check("reset_write_enable", 32'(write_enable), 32'h0);
    instruction = enc_i(12'h0, 5'd0, 3'd2, 5'd8, 7'h03);  // LW while in reset
    #1;
    check("reset_read_enable", 32'(read_enable), 32'h0);
    instruction = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd0);
    #0.5;
    check("reset_x1", alu_out, 32'h0);
    #0.5;
    reset = 1'b0;

    // Directed cases
    issue_k(32'h00500093, 32'h0, 1'b1, 32'd5);                // ADDI x1,x0,5
    issue(32'hFFD00113, 32'h0);                               // ADDI x2,x0,-3
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0);       // SUB  x3,x1,x2
    issue(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4), 32'h0);       // SLT  x4,x2,x1
    issue(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5), 32'h0);       // SLTU x5,x2,x1
    read_reg(5'd3, 32'd8);
    read_reg(5'd4, 32'd1);
    read_reg(5'd5, 32'd0);
    issue(enc_i(12'h401, 5'd2, 3'd5, 5'd6, 7'h13), 32'h0);    // SRAI x6,x2,1
    issue(enc_i(12'h001, 5'd2, 3'd5, 5'd7, 7'h13), 32'h0);    // SRLI x7,x2,1
    read_reg(5'd6, 32'hFFFF_FFFE);
    read_reg(5'd7, 32'h7FFF_FFFE);
    issue(enc_i(12'd16, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0);     // ADDI x1,x0,16
    issue_k(enc_i(12'd4, 5'd1, 3'd0, 5'd8, 7'h03), 32'h0000_00F0, 1'b1, 32'd20);  // LB
    read_reg(5'd8, 32'hFFFF_FFF0);
    issue(enc_i(12'd4, 5'd1, 3'd4, 5'd8, 7'h03), 32'h0000_00F0);  // LBU
    read_reg(5'd8, 32'h0000_00F0);
    issue(enc_i(12'd4, 5'd1, 3'd2, 5'd8, 7'h03), 32'h1234_5678);  // LW
    read_reg(5'd8, 32'h1234_5678);
    issue(enc_i(12'd0, 5'd1, 3'd1, 5'd9, 7'h03), 32'h1234_8001);  // LH
    read_reg(5'd9, 32'hFFFF_8001);
    issue(enc_i(12'd0, 5'd1, 3'd5, 5'd9, 7'h03), 32'h1234_8001);  // LHU
    read_reg(5'd9, 32'h0000_8001);
    issue(enc_i(12'd0, 5'd0, 3'd2, 5'd2, 7'h03), 32'hAABB_CCDD);  // LW x2
    issue_k(enc_s(12'hFFE, 5'd2, 5'd1, 3'd1), 32'h0, 1'b1, 32'd14);  // SH x2,-2(x1)
    read_reg(5'd1, 32'd16);
    read_reg(5'd2, 32'hAABB_CCDD);
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 32'h0);      // ADDI x0,x0,7
    read_reg(5'd0, 32'h0);
    issue(32'h00100073, 32'h0);                               // EBREAK
    issue(enc_i(12'd0, 5'd1, 3'd3, 5'd10, 7'h03), 32'hFFFF_FFFF);  // undefined load
    read_reg(5'd10, 32'h0);
    issue(enc_s(12'd0, 5'd2, 5'd1, 3'd4), 32'h0);             // undefined store
    issue(32'h1234_5537, 32'h0);                              // LUI: unsupported
    read_reg(5'd10, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int          cls;
      logic [31:0] r;
      logic [6:0]  opc;
      r   = $urandom();
      cls = $urandom_range(0, 5);
      case (cls)
        0: issue(enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, r[24:20], r[19:15],
                       r[14:12], r[11:7]), 32'h0);
        1: issue(enc_i(r[31:20], r[19:15], r[14:12], r[11:7], 7'h13), 32'h0);
        2, 3: issue(enc_i(r[31:20], r[19:15], r[14:12], r[11:7], 7'h03), $urandom());
        4: issue(enc_s(r[31:20], r[24:20], r[19:15], r[14:12]), 32'h0);
        default: begin
          do opc = 7'($urandom_range(0, 127));
          while (opc == 7'h33 || opc == 7'h13 || opc == 7'h03 || opc == 7'h23);
          issue({r[31:7], opc}, $urandom());
        end
      endcase
    end
    for (int n = 0; n < 32; n++) read_reg(5'(n), mregs[n]);

    // Mid-cycle reset: x1=5, then reset pulses across an edge with a pending write
    issue(32'h00500093, 32'h0);
    @(posedge clock);
    #1;
    instruction = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd0);
    #1;
    check("pre_reset_x1", alu_out, 32'd5);
    instruction = enc_i(12'h0, 5'd1, 3'd2, 5'd8, 7'h03);
    reset = 1'b1;
    #1;
    check("midreset_read_enable", 32'(read_enable), 32'h0);
    check("midreset_x1", alu_out, 32'h0);
    instruction = enc_s(12'h0, 5'd1, 5'd1, 3'd2);
    #1;
    check("midreset_write_enable", 32'(write_enable), 32'h0);
    instruction = enc_i(12'h055, 5'd0, 3'd0, 5'd9, 7'h13);   // write held off by reset
    @(posedge clock);
    #1;
    instruction = enc_r(7'h00, 5'd0, 5'd9, 3'd0, 5'd0);
    #1;
    check("reset_dropped_write", alu_out, 32'h0);
    reset = 1'b0;
    model_reset();
    #1;
    check("post_reset_x9", alu_out, 32'h0);
    issue(enc_i(12'd3, 5'd1, 3'd0, 5'd11, 7'h13), 32'h0);    // ADDI x11,x1,3
    read_reg(5'd11, 32'd3);
    for (int n = 0; n < 32; n++) read_reg(5'(n), mregs[n]);

    @(negedge clock);
    #1;
`ifdef DEBUG_REG_EN
    for (int n = 0; n < 32; n++) check("debug_reg", debug_reg[32*n +: 32], mregs[n]);
`endif
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_slice.md
Name: rv32i_exec_slice

Overview:
- Single-cycle RV32I execution slice: 32x32 register file, instruction decoder, ALU and load/store access control with write-back.
- Sits between the fetch/PC logic, which supplies pc and instruction each cycle, and the data memory port.
- Everything is combinational from instruction/regfile except register write-back on the rising clock edge.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_VALUE, 32'h0, value loaded into every register on reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- instruction  in  32  current instruction word
- pc  in  32  address of the current instruction
- address  out  32  data memory address; always equals alu_out
- read_data  in  32  load data, already right-aligned to bit 0 by memory
- read_enable  out  1  high for load instructions
- write_data  out  32  store data = rs2 value, unmasked
- write_enable  out  1  high for store instructions
- write_wstrb  out  2  access width: 0=byte, 1=half, 2=word, 3 unused
- alu_out  out  32  ALU result
- debug_ebreak  out  1  high when instruction == 32'h00100073

Behaviour:
- Reset: reset is asynchronous, active-high; all 32 registers are set to RESET_VALUE immediately.
- While reset is high: read_enable=0, write_enable=0, and no write-back occurs.
- x0: reads always return 0; writes to x0 are discarded.
- Decode fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Immediates:
  - I-imm = sign-extended instr[31:20].
  - S-imm = sign-extended {instr[31:25], instr[11:7]}.
- R-type (0110011): op1=rs1, op2=rs2; funct3 selects the operation:
  - 000: ADD (SUB if instr[30]=1)
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL (SRA if instr[30]=1)
  - 110: OR
  - 111: AND
- I-type ALU (0010011): op1=rs1, op2=I-imm.
  - Same funct3 map as R-type, except 000 is always ADD.
  - 101 uses instr[30] to select SRAI over SRLI.
- Load (0000011): op1=rs1, op2=I-imm, ADD; read_enable=1.
  - funct3 000 LB and 100 LBU: wstrb=0.
  - 001 LH and 101 LHU: wstrb=1.
  - 010 LW: wstrb=2.
- Store (0100011): op1=rs1, op2=S-imm, ADD; write_enable=1.
  - funct3 000 SB: wstrb=0; 001 SH: wstrb=1; 010 SW: wstrb=2.
- Any other opcode: op1=rs1, op2=I-imm, ADD; no enables; wstrb=2; no write-back.
- Undefined load/store funct3 (load 011/110/111, store 011-111): no enables, no write-back.
- ALU arithmetic:
  - Shifts use op2[4:0].
  - SLT is signed, SLTU unsigned; both return 32'h1 or 32'h0.
  - Add/sub wrap modulo 2^32.
- Write-back on posedge clock when reset is low:
  - R/I-type: rd <= alu_out.
  - Load: rd <= masked read_data. Masks are 000000FF, 0000FFFF, FFFFFFFF. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Latency: outputs are valid combinationally within the same cycle. A written value is visible to the next instruction after one clock edge.
- Reset asserted mid-cycle: the pending write-back is dropped and the registers clear immediately.
- pc feeds no ALU path in this version (LUI/AUIPC/branch/JAL not supported); it is accepted for future use.

Optional Feature:
- Macro DEBUG_REG_EN.
- Defined: adds output port debug_reg[1023:0], a combinational copy of the register file; bits [32*i+31:32*i] = x[i], x0 field is 0.
- Undefined: the port does not exist and there is no extra logic.

Test Plan:
- Reset then ADDI x1,x0,5 (32'h00500093), clock -> x1=5, alu_out=5 before edge, read_enable=write_enable=0.
- x1=5, x2=-3 (ADDI 32'hFFD00113); SUB x3,x1,x2; SLT x4,x2,x1; SLTU x5,x2,x1 -> x3=8, x4=1, x5=0.
- x2=32'hFFFFFFFD, SRAI x6,x2,1 -> 32'hFFFFFFFE; SRLI x7,x2,1 -> 32'h7FFFFFFE.
- x1=16, LB x8,4(x1) with read_data=32'h000000F0 -> address=20, wstrb=0, read_enable=1, x8=32'hFFFFFFF0; LBU -> 32'h000000F0; LW read_data 32'h12345678 -> x8=32'h12345678.
- x1=16, x2=32'hAABBCCDD, SH x2,-2(x1) -> address=14, write_data=32'hAABBCCDD, wstrb=1, write_enable=1, no register changes.
- ADDI x0,x0,7 -> x0 still reads 0.
- EBREAK (32'h00100073) -> debug_ebreak=1.
- Reset pulsed between edges with x1=5 -> x1=0 immediately, enables 0 during reset.
